// File: rtl/lock_access_fsm.sv
// Access supervisor behind the six-digit lock controller.
// Turns each rising edge of the judge strobe (in entry mode) into one evaluated attempt,
// drives a timed unlock pulse, counts consecutive failures and enforces a timed lockout.
//
// Ports:
//   clk        clock, rising edge
//   clr        synchronous active-low reset
//   m          controller mode: 0 = set password, 1 = enter password
//   judge      judge-select level from the controller decoder
//   res        registered compare result, 1 = code matches
//   unlock     door release, high in OPEN
//   alarm      high in LOCKOUT
//   set_allow  high in OPEN while m = 0; gates password writes upstream
//   fail_cnt   consecutive failures since last success, lockout exit or reset
//   remain     countdown value, 0 outside OPEN and LOCKOUT
//   state      IDLE=0, EVAL=1, OPEN=2, LOCKOUT=3
module lock_access_fsm #(
  parameter int unsigned MAX_FAIL       = 3,
  parameter int unsigned UNLOCK_CYCLES  = 8,
  parameter int unsigned LOCKOUT_CYCLES = 16,
  parameter int unsigned CW             = 8
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          m,
  input  logic          judge,
  input  logic          res,
  output logic          unlock,
  output logic          alarm,
  output logic          set_allow,
  output logic [1:0]    fail_cnt,
  output logic [CW-1:0] remain,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StEval    = 2'd1,
    StOpen    = 2'd2,
    StLockout = 2'd3
  } state_e;

  // Timers are loaded with N-1 so the output stays high for exactly N cycles.
  localparam logic [CW-1:0] UnlockLoad  = CW'(UNLOCK_CYCLES - 1);
  localparam logic [CW-1:0] LockoutLoad = CW'(LOCKOUT_CYCLES - 1);
  localparam logic [1:0]    FailMax     = 2'(MAX_FAIL);

  state_e        state_q, state_d;
  logic [1:0]    fail_cnt_q, fail_cnt_d;
  logic [CW-1:0] remain_q, remain_d;
  logic          judge_q;
  logic          attempt;

  // Only a fresh rising edge in entry mode counts; judge_q tracks in every state so edges
  // seen during EVAL/OPEN/LOCKOUT are consumed rather than replayed.
  assign attempt = judge & ~judge_q & m;

  always_comb begin
    state_d    = state_q;
    fail_cnt_d = fail_cnt_q;
    remain_d   = remain_q;
    unique case (state_q)
      StIdle: begin
        if (attempt) state_d = StEval;
      end
      StEval: begin
        if (res) begin
          state_d    = StOpen;
          fail_cnt_d = 2'd0;
          remain_d   = UnlockLoad;
        end else if (({1'b0, fail_cnt_q} + 3'd1) >= {1'b0, FailMax}) begin
          state_d    = StLockout;
          fail_cnt_d = FailMax;
          remain_d   = LockoutLoad;
        end else begin
          state_d    = StIdle;
          fail_cnt_d = fail_cnt_q + 2'd1;
        end
      end
      StOpen: begin
        if (remain_q == '0) begin
          state_d = StIdle;
        end else begin
          remain_d = remain_q - CW'(1);
        end
      end
      StLockout: begin
        if (remain_q == '0) begin
          state_d    = StIdle;
          fail_cnt_d = 2'd0;
        end else begin
          remain_d = remain_q - CW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q    <= StIdle;
      fail_cnt_q <= 2'd0;
      remain_q   <= '0;
      judge_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fail_cnt_q <= fail_cnt_d;
      remain_q   <= remain_d;
      judge_q    <= judge;
    end
  end

  assign unlock    = (state_q == StOpen);
  assign alarm     = (state_q == StLockout);
  assign set_allow = (state_q == StOpen) & ~m;
  assign fail_cnt  = fail_cnt_q;
  assign remain    = remain_q;
  assign state     = state_q;

endmodule

// File: tb/tb_lock_access_fsm.sv
// Self-checking bench for lock_access_fsm: directed scenarios followed by random stimulus,
// every cycle compared against a countdown-based reference model.
module tb_lock_access_fsm;

  localparam int unsigned MaxFail  = 3;
  localparam int unsigned UnlockN  = 8;
  localparam int unsigned LockoutN = 16;
  localparam int unsigned Cw       = 8;

  logic          clk;
  logic          clr;
  logic          m;
  logic          judge;
  logic          res;
  logic          unlock;
  logic          alarm;
  logic          set_allow;
  logic [1:0]    fail_cnt;
  logic [Cw-1:0] remain;
  logic [1:0]    state;

  lock_access_fsm #(
    .MAX_FAIL      (MaxFail),
    .UNLOCK_CYCLES (UnlockN),
    .LOCKOUT_CYCLES(LockoutN),
    .CW            (Cw)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .m        (m),
    .judge    (judge),
    .res      (res),
    .unlock   (unlock),
    .alarm    (alarm),
    .set_allow(set_allow),
    .fail_cnt (fail_cnt),
    .remain   (remain),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  // Reference model: cycles of unlock/alarm still to come, a pending evaluation flag,
  // the failure streak and the previous judge level.
  int open_left;
  int lock_left;
  bit eval_pend;
  int fails;
  bit jprev;

  int unlock_seen;
  int alarm_seen;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input bit c, input bit mm, input bit j, input bit r);
    bit att;
    if (!c) begin
      open_left = 0;
      lock_left = 0;
      eval_pend = 0;
      fails     = 0;
      jprev     = 0;
      return;
    end
    att   = j && !jprev && mm;
    jprev = j;
    if (eval_pend) begin
      eval_pend = 0;
      if (r) begin
        fails     = 0;
        open_left = UnlockN;
      end else if (fails + 1 >= MaxFail) begin
        fails     = MaxFail;
        lock_left = LockoutN;
      end else begin
        fails++;
      end
    end else if (open_left > 0) begin
      open_left--;
    end else if (lock_left > 0) begin
      lock_left--;
      if (lock_left == 0) fails = 0;
    end else if (att) begin
      eval_pend = 1;
    end
  endtask

  task automatic check_outputs();
    int exp_state;
    int exp_remain;
    if (eval_pend)          exp_state = 1;
    else if (open_left > 0) exp_state = 2;
    else if (lock_left > 0) exp_state = 3;
    else                    exp_state = 0;
    if (open_left > 0)      exp_remain = open_left - 1;
    else if (lock_left > 0) exp_remain = lock_left - 1;
    else                    exp_remain = 0;
    check_eq("state", 32'(state), 32'(exp_state));
    check_eq("remain", 32'(remain), 32'(exp_remain));
    check_eq("fail_cnt", 32'(fail_cnt), 32'(fails));
    check_eq("unlock", 32'(unlock), 32'(open_left > 0));
    check_eq("alarm", 32'(alarm), 32'(lock_left > 0));
    check_eq("set_allow", 32'(set_allow), 32'((open_left > 0) && !m));
  endtask

  // Apply one cycle of inputs, advance the model at the edge, compare just after it.
  task automatic cyc(input bit c, input bit mm, input bit j, input bit r);
    clr   = c;
    m     = mm;
    judge = j;
    res   = r;
    @(posedge clk);
    model_step(c, mm, j, r);
    #1;
    check_outputs();
    if (unlock) unlock_seen++;
    if (alarm)  alarm_seen++;
  endtask

  task automatic run(input int n, input bit c, input bit mm, input bit j, input bit r);
    for (int i = 0; i < n; i++) cyc(c, mm, j, r);
  endtask

  // Single-cycle judge pulse in entry mode followed by idle cycles.
  task automatic attempt_pulse(input bit r, input int gap);
    cyc(1, 1, 1, r);
    run(gap, 1, 1, 0, r);
  endtask

  initial begin
    bit jr;
    n_cmp = 0;
    n_err = 0;
    open_left = 0; lock_left = 0; eval_pend = 0; fails = 0; jprev = 0;
    clr = 0; m = 0; judge = 0; res = 0;

    // Reset.
    run(2, 0, 0, 0, 0);
    run(2, 1, 1, 0, 0);

    // Successful attempt: unlock high for exactly UnlockN cycles.
    unlock_seen = 0;
    attempt_pulse(1, 12);
    check_eq("unlock_len", 32'(unlock_seen), 32'(UnlockN));

    // Three failures spaced 4 cycles apart, then lockout of LockoutN cycles.
    alarm_seen = 0;
    attempt_pulse(0, 3);
    attempt_pulse(0, 3);
    attempt_pulse(0, 22);
    check_eq("alarm_len", 32'(alarm_seen), 32'(LockoutN));

    // Attempt with res=1 during lockout must be ignored.
    alarm_seen  = 0;
    unlock_seen = 0;
    attempt_pulse(0, 3);
    attempt_pulse(0, 3);
    attempt_pulse(0, 4);
    attempt_pulse(1, 20);
    check_eq("lock_ignore_alarm", 32'(alarm_seen), 32'(LockoutN));
    check_eq("lock_ignore_unlock", 32'(unlock_seen), 32'd0);

    // Two failures, then success.
    alarm_seen  = 0;
    unlock_seen = 0;
    attempt_pulse(0, 3);
    attempt_pulse(0, 3);
    attempt_pulse(1, 12);
    check_eq("recover_unlock", 32'(unlock_seen), 32'(UnlockN));
    check_eq("recover_alarm", 32'(alarm_seen), 32'd0);

    // In OPEN drop m: set_allow follows; m=0 judge pulse in IDLE does nothing.
    attempt_pulse(1, 3);
    run(3, 1, 0, 0, 1);
    run(8, 1, 1, 0, 0);
    cyc(1, 0, 1, 1);
    run(4, 1, 0, 0, 1);

    // Held judge level counts once.
    run(20, 1, 1, 1, 0);
    run(2, 1, 1, 0, 0);

    // Reset in the 4th cycle of OPEN.
    attempt_pulse(1, 3);
    cyc(0, 1, 0, 0);
    run(3, 1, 1, 0, 0);

    // Randomized traffic.
    jr = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) jr = ~jr;
      cyc($urandom_range(0, 299) != 0, $urandom_range(0, 7) != 0, jr, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lock_access_fsm.md
# lock_access_fsm

Access supervisor placed directly downstream of the six-digit lock controller. It consumes the controller's compare result `res` and the judge-select strobe, and turns each judge request made in entry mode into one evaluated attempt. It drives a timed unlock pulse, counts consecutive failures and enforces a timed lockout with alarm. It also tells the controller when a password change is permitted.

## Interface
Parameters:
- `MAX_FAIL`, 3: consecutive failed attempts that trigger lockout; legal range 1..3.
- `UNLOCK_CYCLES`, 8: cycles `unlock` stays high per successful attempt; legal range 1..2^CW.
- `LOCKOUT_CYCLES`, 16: cycles `alarm` stays high per lockout; legal range 1..2^CW.
- `CW`, 8: width of the countdown timer.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `clr`, input, 1: reset. Synchronous, active-low: sampled on the rising edge of `clk`; low at an edge resets the block.
- `m`, input, 1: controller mode. 0 = set password, 1 = enter password.
- `judge`, input, 1: judge-select level from the controller's 2-to-4 decoder (y3 output).
- `res`, input, 1: controller compare result, registered upstream; 1 = entered code matches.
- `unlock`, output, 1: door release, high in OPEN.
- `alarm`, output, 1: high in LOCKOUT.
- `set_allow`, output, 1: high in OPEN while `m`=0; gates password writes upstream.
- `fail_cnt`, output, 2: consecutive failures since the last success, lockout exit or reset.
- `remain`, output, CW: current countdown value; 0 outside OPEN and LOCKOUT.
- `state`, output, 2: IDLE=0, EVAL=1, OPEN=2, LOCKOUT=3.

## Operation
- `judge_d` is a register holding `judge` delayed by one cycle.
- attempt = `judge` & ~`judge_d` & `m`. Only a rising edge of `judge` while `m`=1 counts. A held `judge` level counts once.
- IDLE: on attempt, go to EVAL. Otherwise stay.
- EVAL: lasts exactly one cycle. `res` is sampled at the edge that leaves EVAL.
  - `res`=1: go to OPEN, clear `fail_cnt`, load `remain` = UNLOCK_CYCLES-1.
  - `res`=0 and `fail_cnt`+1 < MAX_FAIL: increment `fail_cnt`, go to IDLE.
  - `res`=0 and `fail_cnt`+1 = MAX_FAIL: set `fail_cnt` = MAX_FAIL, load `remain` = LOCKOUT_CYCLES-1, go to LOCKOUT.
- OPEN: decrement `remain` each cycle.
  - An attempt in OPEN is ignored; no re-evaluation and no timer reload.
  - When `remain`=0 at an edge, go to IDLE.
- LOCKOUT: decrement `remain` each cycle.
  - Attempts are ignored and do not extend the lockout.
  - When `remain`=0 at an edge, go to IDLE and clear `fail_cnt`.
- Output decode: `unlock` = (state==OPEN). `alarm` = (state==LOCKOUT). `set_allow` = (state==OPEN) & ~`m`.
- `m` changing in any state does not alter the state or the timer. It only gates new attempts and `set_allow`.
- `judge_d` updates in every state, so an edge that occurs during OPEN or LOCKOUT is consumed and not replayed later.
- Width rules:
  - `fail_cnt` saturates at MAX_FAIL and never wraps.
  - `remain` decrements without underflow: the state exits at 0 and never reaches 2^CW-1.

## Timing
- Reset: `clr` low at an edge sets state=IDLE, `fail_cnt`=0, `remain`=0, `judge_d`=0. Outputs `unlock`, `alarm` and `set_allow` are 0 from the next cycle.
- Reset mid-operation has the same effect: it aborts OPEN or LOCKOUT immediately.
- Outputs are registered state decodes. There is no combinational path from any input to any output except `set_allow` from `m`.
- Attempt latency: `judge` rises before edge E0. EVAL is visible after E0. `res` is sampled at E1. `unlock` or `alarm` rises after E1.
- `unlock` stays high for exactly UNLOCK_CYCLES cycles. `alarm` stays high for exactly LOCKOUT_CYCLES cycles.
- Back-to-back attempts: minimum 2 cycles apart to both be evaluated. An edge arriving during EVAL is dropped.

## Test plan
- Reset, then `m`=1, pulse `judge` with `res`=1 → `state`=1 for 1 cycle, then `unlock`=1 for exactly 8 cycles, `remain` counts 7..0, `fail_cnt`=0.
- Three `judge` pulses with `res`=0, spaced 4 cycles apart → `fail_cnt` goes 1, 2, 3. After the third, `alarm`=1 for 16 cycles. On exit `fail_cnt`=0 and `state`=0.
- During LOCKOUT, pulse `judge` with `res`=1 → ignored. `alarm` duration stays 16, `unlock` never rises.
- Two failures, then one success → `fail_cnt` 1, 2, then 0. `unlock` pulses for 8 cycles with no alarm.
- In OPEN, drop `m` to 0 → `set_allow`=1 on that cycle while `unlock` remains high. `m`=0 with a `judge` pulse in IDLE → no state change.
- Hold `judge` high for 20 cycles with `m`=1 → one attempt only. Assert `clr`=0 at cycle 4 of OPEN → next cycle `unlock`=0, `state`=0, `remain`=0.
